fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of decode/control in the pipelined rv32 core.
- Owns the program counter and issues word fetches to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned instructions in a small prefetch queue and presents {instr, pc, pc+4} to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/rv32_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32 core types and constants used by the fetch stage and its queue.
package rv32_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_pkt_t;

    function automatic word_t word_align(input word_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Sequential instruction address; wraps modulo 2^32.
    function automatic word_t next_pc(input word_t addr);
        return addr + word_t'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of fetch packets between the imem response path and decode.
// Flush wins over push; push is accepted on a full queue only when a pop frees a slot.
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_pkt_t wr_pkt,
    output fetch_pkt_t head_pkt,
    output logic [AW:0] count,
    output logic       empty,
    output logic       full
);

    fetch_pkt_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_pkt = mem[rd_ptr];

    // Storage carries no reset; empty masks its contents at the output.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_pkt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rv32 instruction fetch: owns the PC, issues imem requests, buffers responses
// and hands {instr, pc, pc+4} to decode; redirects flush and drop stale words.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC,
    parameter int    DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_4
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Valid/ready: a transfer happens on a cycle where valid & ready are both
    // high; valid never drops and the payload never changes until that transfer
    // (a redirect is the one event allowed to retarget an unaccepted request).

    word_t        fetch_pc;
    word_t        resp_pc;
    word_t        redirect_target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop;
    logic [CW-1:0] drop_next;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          out_fire;
    fetch_pkt_t    wr_pkt;
    fetch_pkt_t    head_pkt;
    fetch_pkt_t    hold_pkt;
    fetch_pkt_t    out_pkt;

    assign redirect_target = word_align(i_redirect_pc);

    // Queued plus in-flight words never exceed DEPTH, so the queue cannot overflow.
    assign o_imem_req_valid = !rst && ((fifo_count + outstanding) < CW'(DEPTH));
    assign o_imem_addr      = fetch_pc;

    assign req_fire = o_imem_req_valid && i_imem_req_ready;
    assign rsp_fire = i_imem_rsp_valid && (outstanding != '0);
    assign rsp_keep = rsp_fire && (drop == '0) && !i_redirect;
    assign out_fire = o_valid && i_ready;

    always_comb begin
        outstanding_next = outstanding;
        if (req_fire && !rsp_fire) begin
            outstanding_next = outstanding + CW'(1);
        end else if (!req_fire && rsp_fire) begin
            outstanding_next = outstanding - CW'(1);
        end
    end

    // Every word still in flight after a redirect cycle belongs to the old path.
    always_comb begin
        drop_next = drop;
        if (i_redirect) begin
            drop_next = outstanding_next;
        end else if (rsp_fire && (drop != '0)) begin
            drop_next = drop - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            if (i_redirect) begin
                fetch_pc <= redirect_target;
            end else if (req_fire) begin
                fetch_pc <= next_pc(fetch_pc);
            end
            if (i_redirect) begin
                resp_pc <= redirect_target;
            end else if (rsp_keep) begin
                resp_pc <= next_pc(resp_pc);
            end
            outstanding <= outstanding_next;
            drop        <= drop_next;
        end
    end

    assign wr_pkt.instr = i_imem_rsp_data;
    assign wr_pkt.pc    = resp_pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rsp_keep),
        .pop      (out_fire),
        .flush    (i_redirect),
        .wr_pkt   (wr_pkt),
        .head_pkt (head_pkt),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Decode sees the last presented packet while the queue is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_pkt <= '0;
        end else if (!fifo_empty) begin
            hold_pkt <= head_pkt;
        end
    end

    assign out_pkt = fifo_empty ? hold_pkt : head_pkt;
    assign o_valid = !fifo_empty;
    assign o_instr = out_pkt.instr;
    assign o_pc    = out_pkt.pc;
    assign o_pc_4  = next_pc(out_pkt.pc);

    rsp_needs_request: assert property (@(posedge clk) disable iff (rst)
        i_imem_rsp_valid |-> (outstanding != '0));

    push_has_room: assert property (@(posedge clk) disable iff (rst)
        rsp_keep |-> (!fifo_full || out_fire));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order imem model with programmable latency,
// a pc/instr scoreboard on the decode side, and a table of redirect scenarios.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pc_4;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_instr          (o_instr),
        .o_pc             (o_pc),
        .o_pc_4           (o_pc_4)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int icyc    = 0;

    logic [31:0] exp_q[$];
    logic [31:0] acc_q[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend_q[$];

    typedef struct {
        int          lat;
        int          r;
        logic [31:0] t1;
        bit          two;
        logic [31:0] t2;
        logic [31:0] exp_pc;
    } redir_vec_t;
    redir_vec_t vecs[5];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the bench at the start of cycle 0: the first cycle after deassertion.
    task automatic do_reset(input int lat_v, input logic ready_v);
        rst           = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_ready       = 1'b0;
        lat           = lat_v;
        exp_q.delete();
        repeat (3) step();
        rst     = 1'b0;
        i_ready = ready_v;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        i_ready = 1'b0;
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- imem model: in order, fixed latency per test ----------------
    initial begin
        i_imem_req_ready = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            icyc++;
            if (rst) begin
                pend_q.delete();
                acc_q.delete();
                i_imem_rsp_valid = 1'b0;
                i_imem_rsp_data  = '0;
                i_imem_req_ready = 1'b0;
            end else begin
                if (pend_q.size() > 0 && pend_q[0].due <= icyc) begin
                    i_imem_rsp_valid = 1'b1;
                    i_imem_rsp_data  = instr_of(pend_q[0].addr);
                    void'(pend_q.pop_front());
                end else begin
                    i_imem_rsp_valid = 1'b0;
                    i_imem_rsp_data  = '0;
                end
                i_imem_req_ready = 1'b1;
                if (o_imem_req_valid) begin
                    pend_q.push_back('{addr: o_imem_addr, due: icyc + lat});
                    acc_q.push_back(o_imem_addr);
                end
            end
        end
    end

    // ---------------- scoreboard: decode-side transfers ----------------
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop_pc", o_pc, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("o_pc", o_pc, e);
                    check("o_pc_4", o_pc_4, e + 32'd4);
                    check("o_instr", o_instr, instr_of(e));
                end
            end
        end
    end

    initial begin
        #400000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        //          lat  r   t1              two  t2            exp first pc
        vecs[0] = '{lat: 4, r: 2, t1: 32'h0000_0102, two: 1'b0, t2: 32'h0, exp_pc: 32'h0000_0100};
        vecs[1] = '{lat: 2, r: 2, t1: 32'h0000_0200, two: 1'b0, t2: 32'h0, exp_pc: 32'h0000_0200};
        vecs[2] = '{lat: 3, r: 2, t1: 32'h0000_0040, two: 1'b1, t2: 32'h0000_0080, exp_pc: 32'h0000_0080};
        vecs[3] = '{lat: 1, r: 0, t1: 32'hFFFF_FFFC, two: 1'b0, t2: 32'h0, exp_pc: 32'hFFFF_FFFC};
        vecs[4] = '{lat: 1, r: 3, t1: 32'h0000_1003, two: 1'b0, t2: 32'h0, exp_pc: 32'h0000_1000};

        rst           = 1'b1;
        i_ready       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        repeat (2) step();
        #3;
        check("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_instr", o_instr, 32'd0);
        check("rst_o_pc", o_pc, 32'd0);
        check("rst_o_pc_4", o_pc_4, 32'd4);

        // Streaming at latency 1: one instruction per cycle from cycle 2.
        do_reset(1, 1'b1);
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
        #3;
        check("c0_req_valid", 32'(o_imem_req_valid), 32'd1);
        check("c0_addr", o_imem_addr, 32'h0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) #3;
            check($sformatf("stream_valid_c%0d", k), 32'(o_valid), (k >= 2) ? 32'd1 : 32'd0);
            step();
        end
        drain("stream_drain");
        for (int k = 0; k < 8; k++) begin
            check($sformatf("stream_addr%0d", k), acc_q[k], 32'(4 * k));
        end

        // Asynchronous reset in the middle of traffic.
        rst = 1'b1;
        #1;
        check("midrst_req_valid", 32'(o_imem_req_valid), 32'd0);
        check("midrst_o_valid", 32'(o_valid), 32'd0);
        check("midrst_o_pc", o_pc, 32'd0);
        check("midrst_o_pc_4", o_pc_4, 32'd4);

        // Decode stalled for 10 cycles: exactly DEPTH words fetched, then none.
        do_reset(1, 1'b0);
        repeat (9) step();
        #3;
        check("stall_req_valid", 32'(o_imem_req_valid), 32'd0);
        check("stall_accepted", 32'(acc_q.size()), 32'd4);
        check("stall_o_valid", 32'(o_valid), 32'd1);
        step();
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
        i_ready = 1'b1;
        drain("stall_drain");
        for (int k = 0; k < acc_q.size(); k++) begin
            check($sformatf("stall_addr%0d", k), acc_q[k], 32'(4 * k));
        end

        // Redirect scenarios.
        for (int v = 0; v < 5; v++) begin
            do_reset(vecs[v].lat, 1'b0);
            repeat (vecs[v].r) step();
            i_redirect    = 1'b1;
            i_redirect_pc = vecs[v].t1;
            step();
            if (vecs[v].two) begin
                i_redirect_pc = vecs[v].t2;
                step();
            end
            i_redirect = 1'b0;
            #3;
            check($sformatf("redir%0d_o_valid", v), 32'(o_valid), 32'd0);
            check($sformatf("redir%0d_req_valid", v), 32'(o_imem_req_valid), 32'd1);
            check($sformatf("redir%0d_addr", v), o_imem_addr, vecs[v].exp_pc);
            for (int k = 0; k < 6; k++) exp_q.push_back(vecs[v].exp_pc + 32'(4 * k));
            step();
            i_ready = 1'b1;
            drain($sformatf("redir%0d_drain", v));
        end

        // Drop accounting when response, request and redirect share a cycle.
        do_reset(2, 1'b0);
        repeat (2) step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0300;
        step();
        i_redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #3;
            check($sformatf("drop2_quiet_c%0d", k), 32'(o_valid), 32'd0);
            step();
        end
        #3;
        check("drop2_first_valid", 32'(o_valid), 32'd1);
        check("drop2_first_pc", o_pc, 32'h0000_0300);
        check("drop2_first_instr", o_instr, instr_of(32'h0000_0300));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
